// File: rtl/i2c_types_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : i2c_types_pkg                                                   |
// | Brief  : Shared I2C types and constants: slave responder state encoding, |
// |          ACK/NACK bit levels, address match helper.                      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package i2c_types_pkg;

  typedef logic [2:0] i2c_slv_state_t;

  localparam i2c_slv_state_t ST_IDLE     = 3'd0;
  localparam i2c_slv_state_t ST_ADDR     = 3'd1;
  localparam i2c_slv_state_t ST_ADDR_ACK = 3'd2;
  localparam i2c_slv_state_t ST_WR_DATA  = 3'd3;
  localparam i2c_slv_state_t ST_WR_ACK   = 3'd4;
  localparam i2c_slv_state_t ST_RD_DATA  = 3'd5;
  localparam i2c_slv_state_t ST_RD_ACK   = 3'd6;
  localparam i2c_slv_state_t ST_IGNORE   = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // The general-call address (0) never matches, even if configured as own.
  function automatic logic addr_match(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != 7'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : i2c_line_sync                                                   |
// | Brief  : 2-flop synchroniser plus edge register for one I2C line.        |
// |          All flops reset to 1 (idle bus level).                          |
// | Ports  : i_clk, i_rst (sync, active-high), i_d raw line,                 |
// |          o_level synchronised level, o_rise / o_fall edge pulses.        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/i2c_multibus_slave_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module : i2c_multibus_slave_responder                                    |
// | Brief  : Cycle-accurate I2C slave engine attachable to one of NUM_BUSSES |
// |          busses. Address match, pointer + register-file writes, reads    |
// |          with pointer auto-increment, START/STOP/write/read pulses.      |
// | Ports  : clk_i, rst_i (sync, active-high), bus_sel_i (latched in IDLE),  |
// |          scl_i/sda_i raw lines, sda_o open-drain drive (1 = release),    |
// |          start_o/stop_o/wr_valid_o/rd_valid_o pulses, wr_data_o held,    |
// |          ptr_o register pointer, busy_o (state != IDLE).                 |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module i2c_multibus_slave_responder
  import i2c_types_pkg::*;
#(
  parameter int                        NUM_BUSSES     = 16,
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        MEM_DEPTH      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [$clog2(NUM_BUSSES)-1:0] bus_sel_i,
  input  logic [NUM_BUSSES-1:0]         scl_i,
  input  logic [NUM_BUSSES-1:0]         sda_i,
  output logic [NUM_BUSSES-1:0]         sda_o,
  output logic                          start_o,
  output logic                          stop_o,
  output logic                          wr_valid_o,
  output logic [I2C_DATA_WIDTH-1:0]     wr_data_o,
  output logic                          rd_valid_o,
  output logic [$clog2(MEM_DEPTH)-1:0]  ptr_o,
  output logic                          busy_o
);

  localparam int         SEL_W    = $clog2(NUM_BUSSES);
  localparam int         PTR_W    = $clog2(MEM_DEPTH);
  localparam int         DW       = I2C_DATA_WIDTH;
  localparam logic [3:0] BIT_LAST = 4'(DW - 1);
  localparam logic [3:0] BIT_ALL  = 4'(DW);

  i2c_slv_state_t    r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [DW-1:0]     r_shift;
  logic [3:0]        r_bitcnt;
  logic              r_first;
  logic              r_rw;
  logic              r_acking;
  logic              r_sda_drv;
  logic [PTR_W-1:0]  r_ptr;
  logic [DW-1:0]     r_wr_data;
  logic              r_start;
  logic              r_stop;
  logic              r_wr_valid;
  logic              r_rd_valid;
  logic [DW-1:0]     r_mem [MEM_DEPTH];

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  // Line selection happens before synchronisation, so only one pair of
  // synchronisers is needed regardless of the bus count.
  i2c_line_sync u_scl_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_d     (scl_i[r_sel]),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_d     (sda_i[r_sel]),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // SDA edges only count as bus conditions while SCL is high.
  logic w_start_det, w_stop_det;
  assign w_start_det = w_sda_fall & w_scl;
  assign w_stop_det  = w_sda_rise & w_scl;

  logic [DW-1:0]    w_byte;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_byte_done;
  logic             w_mem_we;
  assign w_byte      = {r_shift[DW-2:0], w_sda};
  assign w_ptr_next  = r_ptr + PTR_W'(1);
  assign w_byte_done = w_scl_rise && (r_bitcnt == BIT_LAST);
  assign w_mem_we    = !w_start_det && !w_stop_det && (r_state == ST_WR_DATA)
                       && w_byte_done && !r_first;

  // Register file is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_mem_we) begin
      r_mem[r_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_first    <= 1'b0;
      r_rw       <= 1'b0;
      r_acking   <= 1'b0;
      r_sda_drv  <= 1'b1;
      r_ptr      <= '0;
      r_wr_data  <= '0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      if (w_stop_det) begin
        r_state   <= ST_IDLE;
        r_sda_drv <= 1'b1;
        r_stop    <= 1'b1;
      end else if (w_start_det) begin
        // Partial byte is dropped; pointer survives a repeated START.
        r_state   <= ST_ADDR;
        r_bitcnt  <= '0;
        r_sda_drv <= 1'b1;
        r_start   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: r_sel <= bus_sel_i;
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (w_byte_done) begin
                r_bitcnt <= '0;
                r_acking <= 1'b0;
                r_rw     <= w_sda;
                r_state  <= addr_match(w_byte[DW-1:1], SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
              end
            end
          end
          ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (w_byte_done) begin
                r_bitcnt <= '0;
                r_acking <= 1'b0;
                r_state  <= ST_WR_ACK;
                if (r_first) begin
                  r_ptr   <= w_byte[PTR_W-1:0];
                  r_first <= 1'b0;
                end else begin
                  r_wr_data  <= w_byte;
                  r_wr_valid <= 1'b1;
                  r_ptr      <= w_ptr_next;
                end
              end
            end
          end
          // First SCL fall (end of bit 8) starts the ACK drive, the second
          // (end of the ACK bit) releases it and opens the next byte.
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_acking) begin
                r_sda_drv <= I2C_ACK;
                r_acking  <= 1'b1;
              end else begin
                r_acking <= 1'b0;
                r_bitcnt <= '0;
                if ((r_state == ST_ADDR_ACK) && r_rw) begin
                  // This fall opens the low phase of the first read bit.
                  r_shift   <= r_mem[r_ptr];
                  r_sda_drv <= r_mem[r_ptr][DW-1];
                  r_state   <= ST_RD_DATA;
                end else begin
                  r_sda_drv <= 1'b1;
                  r_state   <= ST_WR_DATA;
                  if (r_state == ST_ADDR_ACK) begin
                    r_first <= 1'b1;
                  end
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[DW-2:0], 1'b0};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == BIT_ALL) begin
                r_sda_drv <= 1'b1;
                r_bitcnt  <= '0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_sda_drv <= r_shift[DW-1];
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_rd_valid <= 1'b1;
              r_ptr      <= w_ptr_next;
              if (w_sda == I2C_NACK) begin
                r_state <= ST_IGNORE;
              end else begin
                // MSB of the next byte goes out on the following SCL fall.
                r_shift  <= r_mem[w_ptr_next];
                r_bitcnt <= '0;
                r_state  <= ST_RD_DATA;
              end
            end
          end
          ST_IGNORE: r_sda_drv <= 1'b1;
          default:   r_state   <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    sda_o        = '1;
    sda_o[r_sel] = r_sda_drv;
  end

  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign wr_valid_o = r_wr_valid;
  assign wr_data_o  = r_wr_data;
  assign rd_valid_o = r_rd_valid;
  assign ptr_o      = r_ptr;
  assign busy_o     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/i2c_multibus_slave_responder.md
# i2c_multibus_slave_responder

Synthesizable, parametrised I2C slave responder for the multi-bus controller benches: one slave engine attached to any of `NUM_BUSSES` I2C busses, selected at runtime. It replaces behavioural-only slave BFMs wherever gate-level or emulation runs need a cycle-accurate target. It implements address match, a write pointer plus write-data storage, read data return from an internal register file, and per-transfer event pulses. It sits on the shared `scl`/`sda` tri nets next to the controller DUT outputs, with open-drain drive.

## Interface

- `NUM_BUSSES`, default 16: number of I2C busses monitored.
- `I2C_ADDR_WIDTH`, default 7: slave address width; only 7 is legal.
- `I2C_DATA_WIDTH`, default 8: byte width.
- `SLAVE_ADDR`, default 7'h22: address the engine answers.
- `MEM_DEPTH`, default 16: register-file entries; must be a power of two, ≤256.

Ports:

- `clk_i`, in, 1: system clock. One clock only.
- `rst_i`, in, 1: reset, **synchronous, active-high**.
- `bus_sel_i`, in, $clog2(NUM_BUSSES): bus to attach; sampled only in IDLE.
- `scl_i`, in, NUM_BUSSES: raw SCL lines.
- `sda_i`, in, NUM_BUSSES: raw SDA lines.
- `sda_o`, out, NUM_BUSSES: open-drain drive; 0 pulls low, 1 releases. Non-selected bits are always 1.
- `start_o`, out, 1: one-cycle pulse on START or repeated START.
- `stop_o`, out, 1: one-cycle pulse on STOP.
- `wr_valid_o`, out, 1: one-cycle pulse; a data byte was written to the register file.
- `wr_data_o`, out, I2C_DATA_WIDTH: last written byte, held.
- `rd_valid_o`, out, 1: one-cycle pulse; a read byte was acknowledged or NACKed by the master.
- `ptr_o`, out, $clog2(MEM_DEPTH): current register pointer.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation

States:

- **IDLE**: latch `bus_sel_i` into `sel_q`. On START, go to ADDR.
- **ADDR**: shift 8 bits MSB first (address plus R/W) on SCL rising edges.
  - On match, go to ADDR_ACK.
  - On mismatch, go to IGNORE.
- **ADDR_ACK**: pull SDA low for one SCL period.
  - If W, go to WR_DATA with `first_byte=1`.
  - If R, load `shift=mem[ptr]` and go to RD_DATA.
- **WR_DATA**: shift 8 bits, then go to WR_ACK.
  - If `first_byte`, `ptr←byte mod MEM_DEPTH` and no `wr_valid_o` pulse.
  - Otherwise, `mem[ptr]←byte`, `wr_valid_o` pulses, and `ptr←ptr+1` with wrap.
- **WR_ACK**: drive ACK (0), then return to WR_DATA.
- **RD_DATA**: drive `shift` MSB first, one bit per SCL low phase. After 8 bits, go to RD_ACK.
- **RD_ACK**: release SDA and sample the master ACK/NACK on SCL rise. `rd_valid_o` pulses and `ptr←ptr+1` with wrap.
  - ACK: load the next byte and go to RD_DATA.
  - NACK: go to IGNORE.
- **IGNORE**: SDA released; wait for STOP (go to IDLE) or repeated START (go to ADDR).

Boundary conditions:

- **STOP in any state:** go to IDLE. A partial byte is discarded, with no pulse and no write.
- **Repeated START in any non-IDLE state:** go to ADDR. The partial byte is discarded and `ptr` is kept.
- **General call (address 0):** treated as a mismatch.
- **`bus_sel_i` change while busy:** ignored until IDLE.
- **START and STOP detection:** both are gated by SCL high. An SDA edge while SCL is low is data, not a condition.
- **Pointer wrap:** the pointer wraps from MEM_DEPTH-1 to 0 on both writes and reads.
- **Reset:** the register file is not cleared by reset; its contents are undefined until written.

## Timing

- **Synchronisers:** SCL and SDA pass through a 2-flop synchroniser plus an edge register. An event is seen 3 `clk_i` cycles after the pin changes.
- **Sampling:** data bits are sampled on the detected SCL rise.
- **Drive update:** `sda_o` updates on the cycle after a detected SCL fall, i.e. 4 cycles after the pin fall. This requires f_clk ≥ 20×f_SCL; 100 MHz versus 400 kHz is well within this.
- **Pulse timing:** `start_o` and `stop_o` assert 3 cycles after the SDA edge. `wr_valid_o` asserts the cycle after the 8th data-bit sample.
- **ACK release:** the ACK drive is released on the SCL fall that ends the ACK bit.
- **Reset values:**
  - `sda_o` = all 1s; `start_o`, `stop_o`, `wr_valid_o`, `rd_valid_o`, `busy_o` = 0.
  - `wr_data_o` = 0; `ptr_o` = 0.
  - State = IDLE; `sel_q` = 0.
  - Synchroniser flops reset to 1 (idle bus).
- **Reset mid-transfer:** SDA is released on the clock edge where `rst_i` is sampled high.

## Structure

- `i2c_types_pkg` gains:
  - `i2c_slv_state_t` (the 8 states above);
  - `I2C_ACK=1'b0`;
  - `I2C_NACK=1'b1`.
- Sub-module `i2c_line_sync`: 2-flop synchroniser plus rise/fall pulse outputs, reset value 1. It is instantiated twice (SCL and SDA) on the selected bus after the `sel_q` mux.
- The register file is a plain flop array.

## Test plan

- **Write with pointer:** bus 3, write to 0x22 with bytes 0x05, 0xA1, 0xB2 then STOP.
  - Expect `mem[5]=0xA1`, `mem[6]=0xB2`.
  - Expect 2 `wr_valid_o` pulses and `ptr_o=7`.
  - Bus 3 `sda_o` is low exactly in the 4 ACK slots.
  - All other `sda_o` bits stay 1.
- **Read with wrap:** preload 0x0E/0x0F/0x00 with 0x11, 0x22, 0x33. Write pointer 0x0E, repeated START, read 3 bytes, NACK the last.
  - Expect data 0x11, 0x22, 0x33 and 3 `rd_valid_o` pulses.
  - Expect `ptr_o=1`, then IGNORE, then IDLE on STOP.
- **Address mismatch:** address 0x23 → no ACK (SDA stays released), `busy_o` high until STOP, no pulses.
- **Abort:** STOP after 4 data bits of a write → no write and no `wr_valid_o`; IDLE 3 cycles after the SDA rise.
- **Bus select while busy:** change `bus_sel_i` 3→7 mid-transfer → engine stays on bus 3 and switches to bus 7 only after STOP.
- **Reset mid-read:** assert `rst_i` while driving a 0 bit → `sda_o` all 1s on the next edge; all outputs at their reset values.
